// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants, line idle level.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional build macro UART_TX_PARITY_EN adds the PARITY state to uart_tx_state_t.
package uart_pkg;

    localparam int   UART_DATA_BITS            = 8;
    localparam int   UART_DEFAULT_CLKS_PER_BIT = 434;
    // Level of an idle (marking) line; the receiver uses it as well.
    localparam logic UART_IDLE_LEVEL           = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_timer.sv
// Reloadable bit-time counter: bit_tick_o marks the last cycle of every bit period.
// Latency: first tick CLKS_PER_BIT cycles after reload_i drops; then every CLKS_PER_BIT cycles.
// Backpressure: none; reload_i holds the count at zero and suppresses the tick.
// Ports: clk, rst (async active-high), reload_i (hold/restart), bit_tick_o (end of bit period).
module uart_baud_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_i,
    output logic bit_tick_o
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter restarts by itself at every tick, so each bit gets a full period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (reload_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign bit_tick_o = !reload_i && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN): one-byte holding register feeding a shifter.
// Latency: accepting edge -> start bit 1 cycle when idle; frame = 10 (11) * CLKS_PER_BIT cycles.
// Backpressure: tx_ready low while the holding register is full; writes made then are dropped.
// Ports: clk, rst (async active-high), tx_byte/tx_write (CPU write), tx_ready (holding empty),
//        tx_busy (frame in progress), tx_done_int (1-cycle pulse leaving STOP), uart_out (serial line).
// Build macro: UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_byte,
    input  logic                      tx_write,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic                      tx_done_int,
    output logic                      uart_out
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_full_q, hold_full_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      line_q, line_d;
    logic                      done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic bit_tick;
    logic wr_accept;
    logic load_shift;

    uart_baud_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_timer (
        .clk        (clk),
        .rst        (rst),
        .reload_i   (state_q == IDLE),
        .bit_tick_o (bit_tick)
    );

    assign wr_accept = tx_write && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        line_d      = line_q;
        done_d      = 1'b0;
        load_shift  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (wr_accept) begin
            hold_d      = tx_byte;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                load_shift = hold_full_q;
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    line_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        line_d  = parity_q;
`else
                        state_d = STOP;
                        line_d  = UART_IDLE_LEVEL;
`endif
                    end else begin
                        // Shift right so the next bit to send is always at [1] before the shift.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        line_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    line_d  = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        load_shift = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = UART_IDLE_LEVEL;
            end
        endcase

        // Holding byte moves to the shifter and the start bit goes out on the same edge.
        // A write cannot collide here: tx_ready is low whenever the holding register is full.
        if (load_shift) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = '0;
            line_d      = ~UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            line_q      <= UART_IDLE_LEVEL;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            line_q      <= line_d;
            done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_ready    = !hold_full_q;
    assign tx_busy     = (state_q != IDLE);
    assign tx_done_int = done_q;
    assign uart_out    = line_q;

endmodule
